// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - CPU port, DMA port and SRAM pad bundle for sram_arbiter
interface sram_arbiter_if;
  logic        booting;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_overrun;
  logic        dma_req;
  logic        dma_we;
  logic [17:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        RAMCS_b;
  logic        RAMOE_b;
  logic        RAMWE_b;
  logic [17:0] ADR;
  logic [7:0]  dat_out;
  logic        dat_oe;
  logic [7:0]  dat_in;

  modport slave (
    input  booting, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dat_in,
    output cpu_rdata, cpu_done, cpu_overrun, dma_rdata, dma_ack,
    output RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe
  );

  modport master (
    output booting, cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dat_in,
    input  cpu_rdata, cpu_done, cpu_overrun, dma_rdata, dma_ack,
    input  RAMCS_b, RAMOE_b, RAMWE_b, ADR, dat_out, dat_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - SRAM cycle sequencer with strict-priority CPU port and req/ack DMA port
module sram_arbiter #(
  parameter int READ_CYCLES = 2,
  parameter int WE_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          nRESET,
  sram_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WS, WP, WH} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        owner_cpu, owner_cpu_n;
  logic [17:0] adr, adr_n;
  logic [7:0]  wdata, wdata_n;
  logic        cpu_pending;
  logic        cpu_rnw_q;
  logic [17:0] cpu_addr_q;
  logic [7:0]  cpu_wdata_q;
  logic        cpu_grant, dma_grant, finish;
  logic        cpu_done, dma_ack, cpu_overrun;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        cs_b, oe_b, we_b, dat_oe;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    owner_cpu_n = owner_cpu;
    adr_n       = adr;
    wdata_n     = wdata;
    cpu_grant   = 1'b0;
    dma_grant   = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        // A held dma_req is ignored in its own ack clock so it is not granted twice.
        cpu_grant = cpu_pending && !bus.booting;
        dma_grant = !cpu_grant && bus.dma_req && !dma_ack;
        cnt_n     = 4'(READ_CYCLES - 1);
        if (cpu_grant) begin
          owner_cpu_n = 1'b1;
          adr_n       = cpu_addr_q;
          wdata_n     = cpu_wdata_q;
          state_n     = cpu_rnw_q ? RD : WS;
        end else if (dma_grant) begin
          owner_cpu_n = 1'b0;
          adr_n       = bus.dma_addr;
          wdata_n     = bus.dma_wdata;
          state_n     = bus.dma_we ? WS : RD;
        end
      end
      RD: begin
        if (cnt == 4'd0) begin
          finish  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      WS: begin
        state_n = WP;
        cnt_n   = 4'(WE_CYCLES - 1);
      end
      WP: begin
        if (cnt == 4'd0) state_n = WH;
        else             cnt_n   = cnt - 4'd1;
      end
      WH: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      owner_cpu   <= 1'b0;
      adr         <= 18'd0;
      wdata       <= 8'd0;
      cpu_pending <= 1'b0;
      cpu_rnw_q   <= 1'b1;
      cpu_addr_q  <= 18'd0;
      cpu_wdata_q <= 8'd0;
      cpu_done    <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_overrun <= 1'b0;
      cpu_rdata   <= 8'd0;
      dma_rdata   <= 8'd0;
      cs_b        <= 1'b1;
      oe_b        <= 1'b1;
      we_b        <= 1'b1;
      dat_oe      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      owner_cpu <= owner_cpu_n;
      adr       <= adr_n;
      wdata     <= wdata_n;
      cpu_done  <= finish && owner_cpu;
      dma_ack   <= finish && !owner_cpu;
      if (finish && state == RD) begin
        if (owner_cpu) cpu_rdata <= bus.dat_in;
        else           dma_rdata <= bus.dat_in;
      end
      // Strobes are registered from the next state so they line up with it exactly.
      cs_b   <= (state_n == IDLE);
      oe_b   <= (state_n != RD);
      we_b   <= (state_n != WP);
      dat_oe <= (state_n == WS) || (state_n == WP) || (state_n == WH);
      if (bus.booting) begin
        cpu_pending <= 1'b0;
      end else if (bus.cpu_req) begin
        cpu_pending <= 1'b1;
        cpu_rnw_q   <= bus.cpu_rnw;
        cpu_addr_q  <= bus.cpu_addr;
        cpu_wdata_q <= bus.cpu_wdata;
        if (cpu_pending || (state != IDLE && owner_cpu)) cpu_overrun <= 1'b1;
      end else if (cpu_grant) begin
        cpu_pending <= 1'b0;
      end
    end
  end

  assign bus.cpu_rdata   = cpu_rdata;
  assign bus.cpu_done    = cpu_done;
  assign bus.cpu_overrun = cpu_overrun;
  assign bus.dma_rdata   = dma_rdata;
  assign bus.dma_ack     = dma_ack;
  assign bus.RAMCS_b     = cs_b;
  assign bus.RAMOE_b     = oe_b;
  assign bus.RAMWE_b     = we_b;
  assign bus.ADR         = adr;
  assign bus.dat_out     = wdata;
  assign bus.dat_oe      = dat_oe;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural SRAM
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic nRESET = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if bus();
  sram_arbiter #(.READ_CYCLES(2), .WE_CYCLES(2)) dut (
    .clk(clk), .nRESET(nRESET), .bus(bus.slave)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
    int         issue;
    int         due;
  } exp_t;

  exp_t cq[$];
  exp_t dq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] mem [0:262143];
  int   wcnt [0:262143];
  logic prev_we = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!nRESET) mem[18'h0C123] <= 8'h5A;
    else if (!bus.RAMCS_b && !bus.RAMWE_b && bus.dat_oe) mem[bus.ADR] <= bus.dat_out;
  end
  assign bus.dat_in = (!bus.RAMCS_b && !bus.RAMOE_b) ? mem[bus.ADR] : 8'h00;

  always @(negedge clk) begin
    if (prev_we && !bus.RAMWE_b) wcnt[bus.ADR] <= wcnt[bus.ADR] + 1;
    prev_we <= bus.RAMWE_b;
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic rd, input logic [7:0] d, input int issue, input int due);
    exp_t e;
    e.rd = rd; e.d = d; e.issue = issue; e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (nRESET && bus.cpu_done) begin
      if (cq.size() == 0) chk("cpu_done_spurious", int'(bus.cpu_done), 0);
      else begin
        e = cq.pop_front();
        if (e.rd) chk("cpu_rdata", int'(bus.cpu_rdata), int'(e.d));
        if (e.due >= 0) chk("cpu_done_cycle", cyc, e.due);
        else chk("cpu_latency_le10", int'((cyc - e.issue) <= 10), 1);
      end
    end
    if (nRESET && bus.dma_ack) begin
      if (dq.size() == 0) chk("dma_ack_spurious", int'(bus.dma_ack), 0);
      else begin
        e = dq.pop_front();
        if (e.rd) chk("dma_rdata", int'(bus.dma_rdata), int'(e.d));
        if (e.due >= 0) chk("dma_ack_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int t = 0;
    while ((cq.size() != 0 || dq.size() != 0) && t < maxc) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", cq.size() + dq.size(), 0);
  endtask

  task automatic cpu_drive(input logic rnw, input logic [17:0] a, input logic [7:0] d);
    bus.cpu_rnw = rnw; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
  endtask

  task automatic dma_stream(input int base, input int n, input logic [7:0] salt);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.dma_we = 1'b1; bus.dma_addr = 18'(base + i);
      bus.dma_wdata = 8'(i) ^ salt; bus.dma_req = 1'b1;
      dq.push_back(mk(1'b0, 8'(i) ^ salt, cyc, -1));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.dma_ack && t < 100);
      if (!bus.dma_ack) begin
        chk("dma_stream_ack_timeout", int'(bus.dma_ack), 1);
        break;
      end
    end
    bus.dma_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int nbad;
    int acks;
    logic [6:0] p_a, p_b;
    bus.booting = 1'b0; bus.cpu_req = 1'b0; bus.cpu_rnw = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (3) tick();
    nRESET = 1'b1;
    chk("rst_cs_b", int'(bus.RAMCS_b), 1);
    chk("rst_oe_b", int'(bus.RAMOE_b), 1);
    chk("rst_we_b", int'(bus.RAMWE_b), 1);
    chk("rst_dat_oe", int'(bus.dat_oe), 0);
    chk("rst_adr", int'(bus.ADR), 0);
    chk("rst_cpu_rdata", int'(bus.cpu_rdata), 0);
    chk("rst_dma_rdata", int'(bus.dma_rdata), 0);
    chk("rst_cpu_done", int'(bus.cpu_done), 0);
    chk("rst_dma_ack", int'(bus.dma_ack), 0);
    chk("rst_overrun", int'(bus.cpu_overrun), 0);

    // CPU read: grant two edges after the strobe is driven, OE low for 2 clocks.
    tick(); e0 = cyc;
    cpu_drive(1'b1, 18'h0C123, 8'h00);
    cq.push_back(mk(1'b1, 8'h5A, e0, e0 + 4));
    p_a = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      p_a[j] = bus.RAMOE_b;
      if (j == 1) bus.cpu_req = 1'b0;
    end
    chk("cpu_rd_oe_pattern", int'(p_a[4:0]), 'b10011);
    drain(50);

    // CPU write: WS, WP, WP, WH then done.
    tick(); e0 = cyc;
    cpu_drive(1'b0, 18'h01000, 8'hA5);
    cq.push_back(mk(1'b0, 8'h00, e0, e0 + 6));
    p_a = '0; p_b = '0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      p_a[j] = bus.RAMWE_b;
      p_b[j] = bus.dat_oe;
      if (j == 1) bus.cpu_req = 1'b0;
    end
    chk("cpu_wr_we_pattern", int'(p_a), 'b1100111);
    chk("cpu_wr_oe_pattern", int'(p_b), 'b0111100);
    drain(50);
    chk("cpu_wr_mem", int'(mem[18'h01000]), 'hA5);

    // Same-clock cpu_req and dma_req from IDLE: DMA wins, CPU granted in the ack clock.
    tick(); e0 = cyc;
    cpu_drive(1'b1, 18'h01000, 8'h00);
    bus.dma_we = 1'b1; bus.dma_addr = 18'h00200; bus.dma_wdata = 8'h33; bus.dma_req = 1'b1;
    dq.push_back(mk(1'b0, 8'h00, e0, e0 + 5));
    cq.push_back(mk(1'b1, 8'hA5, e0, e0 + 8));
    tick(); bus.cpu_req = 1'b0;
    for (int t = 0; t < 20 && !bus.dma_ack; t++) @(negedge clk);
    bus.dma_req = 1'b0;
    drain(50);
    chk("dma_wr_mem", int'(mem[18'h00200]), 'h33);

    tick(); e0 = cyc;
    bus.dma_we = 1'b0; bus.dma_addr = 18'h00200; bus.dma_req = 1'b1;
    dq.push_back(mk(1'b1, 8'h33, e0, e0 + 3));
    for (int t = 0; t < 20 && !bus.dma_ack; t++) @(negedge clk);
    bus.dma_req = 1'b0;
    drain(50);

    // Continuous DMA writes with a CPU strobe every 40 clocks.
    tick();
    fork
      dma_stream(32'h02000, 20, 8'hA0);
      begin
        for (int k = 0; k < 4; k++) begin
          tick(); e0 = cyc;
          case (k)
            0: begin cpu_drive(1'b1, 18'h0C123, 8'h00); cq.push_back(mk(1'b1, 8'h5A, e0, -1)); end
            1: begin cpu_drive(1'b0, 18'h03000, 8'h77); cq.push_back(mk(1'b0, 8'h00, e0, -1)); end
            2: begin cpu_drive(1'b1, 18'h03000, 8'h00); cq.push_back(mk(1'b1, 8'h77, e0, -1)); end
            default: begin cpu_drive(1'b1, 18'h01000, 8'h00); cq.push_back(mk(1'b1, 8'hA5, e0, -1)); end
          endcase
          tick(); bus.cpu_req = 1'b0;
          repeat (38) tick();
        end
      end
    join
    drain(100);
    nbad = 0;
    for (int i = 0; i < 20; i++)
      if (wcnt[18'h02000 + i] != 1 || mem[18'h02000 + i] !== (8'(i) ^ 8'hA0)) nbad++;
    chk("stress_dma_writes_once", nbad, 0);

    // Booting: CPU strobes must never reach the bus.
    tick(); bus.booting = 1'b1;
    fork
      dma_stream(32'h10000, 256, 8'h5C);
      begin
        for (int k = 0; k < 3; k++) begin
          repeat (100) tick();
          cpu_drive(1'b0, 18'h10005, 8'hEE);
          tick(); bus.cpu_req = 1'b0;
        end
      end
    join
    drain(100);
    tick(); bus.booting = 1'b0;
    nbad = 0;
    for (int i = 0; i < 256; i++)
      if (wcnt[18'h10000 + i] != 1 || mem[18'h10000 + i] !== (8'(i) ^ 8'h5C)) nbad++;
    chk("boot_dma_writes_once", nbad, 0);
    chk("boot_mem_10005", int'(mem[18'h10005]), 'h59);
    tick(); e0 = cyc;
    cpu_drive(1'b1, 18'h10005, 8'h00);
    cq.push_back(mk(1'b1, 8'h59, e0, e0 + 4));
    tick(); bus.cpu_req = 1'b0;
    drain(50);

    // Reset in the middle of WP.
    tick();
    bus.dma_we = 1'b1; bus.dma_addr = 18'h00300; bus.dma_wdata = 8'h44; bus.dma_req = 1'b1;
    tick(); tick();
    chk("wp_we_low", int'(bus.RAMWE_b), 0);
    nRESET = 1'b0; bus.dma_req = 1'b0;
    tick();
    chk("rst_mid_we_b", int'(bus.RAMWE_b), 1);
    chk("rst_mid_dat_oe", int'(bus.dat_oe), 0);
    chk("rst_mid_cs_b", int'(bus.RAMCS_b), 1);
    nRESET = 1'b1;
    acks = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.dma_ack) acks++;
    end
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_overrun", int'(bus.cpu_overrun), 0);

    // Second strobe before cpu_done sets overrun; both accesses still complete.
    tick(); e0 = cyc;
    cpu_drive(1'b1, 18'h01000, 8'h00);
    cq.push_back(mk(1'b1, 8'hA5, e0, e0 + 4));
    tick();
    cpu_drive(1'b1, 18'h0C123, 8'h00);
    cq.push_back(mk(1'b1, 8'h5A, e0 + 1, e0 + 7));
    tick(); bus.cpu_req = 1'b0;
    drain(50);
    chk("overrun_set", int'(bus.cpu_overrun), 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
